// File: rtl/dct_mac_sequencer.sv
// Drives macu clear/enable/tap-select per coefficient, then drains, loads the result and offers it.
// TAPS+LAT+2 cycles per coefficient; res_ready low holds OFFER, ena low freezes everything.
module dct_mac_sequencer #(
  parameter int TAPS  = 8,
  parameter int COEFS = 8,
  parameter int LAT   = 2,
  parameter int TW    = 3,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  output logic          busy,
  output logic          mac_clr,
  output logic          mac_ena,
  output logic [TW-1:0] tap_idx,
  output logic          res_ld,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] coef_idx,
  output logic          done,
  output logic          overrun
);

  // One counter serves both the tap index and the drain countdown.
  localparam int NW = (TW > $clog2(LAT + 1)) ? TW : $clog2(LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_LOAD,
    S_OFFER
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] coef_q, coef_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      coef_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coef_q  <= coef_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coef_d  = coef_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (start & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          cnt_d   = '0;
          coef_d  = '0;
        end
      end
      S_MAC: begin
        if (cnt_q == NW'(TAPS - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = NW'(LAT);
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == NW'(1)) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - NW'(1);
        end
      end
      S_LOAD: state_d = S_OFFER;
      S_OFFER: begin
        if (res_ready) begin
          if (coef_q == CW'(COEFS - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_MAC;
            coef_d  = coef_q + CW'(1);
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are gated by ena so a frozen cycle never clears, accumulates or loads.
  assign busy      = (state_q != S_IDLE);
  assign mac_ena   = ena & (state_q == S_MAC);
  assign mac_clr   = ena & (state_q == S_MAC) & (cnt_q == '0);
  assign tap_idx   = (state_q == S_MAC) ? cnt_q[TW-1:0] : '0;
  assign res_ld    = ena & (state_q == S_LOAD);
  assign res_valid = (state_q == S_OFFER);
  assign coef_idx  = coef_q;
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Bench for dct_mac_sequencer: directed scenarios plus random ena/ready/start against a position-based model.
module tb_dct_mac_sequencer;

  localparam int TAPS  = 8;
  localparam int COEFS = 8;
  localparam int LAT   = 2;
  localparam int TW    = 3;
  localparam int CW    = 3;
  localparam int LDP   = TAPS + LAT;      // position of the load cycle within a coefficient
  localparam int OFF   = TAPS + LAT + 1;  // position of the offer cycle

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena = 1'b0;
  logic          start = 1'b0;
  logic          res_ready = 1'b0;
  logic          busy, mac_clr, mac_ena, res_ld, res_valid, done, overrun;
  logic [TW-1:0] tap_idx;
  logic [CW-1:0] coef_idx;

  dct_mac_sequencer #(.TAPS(TAPS), .COEFS(COEFS), .LAT(LAT), .TW(TW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .busy(busy),
    .mac_clr(mac_clr), .mac_ena(mac_ena), .tap_idx(tap_idx), .res_ld(res_ld),
    .res_valid(res_valid), .res_ready(res_ready), .coef_idx(coef_idx),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a block is "active" with an elapsed position m_p inside the current coefficient.
  bit m_active, m_done, m_ovr;
  int m_p, m_coef;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_ovr <= 1'b0; m_p <= 0; m_coef <= 0;
    end else if (ena) begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (start) begin m_active <= 1'b1; m_p <= 0; m_coef <= 0; end
      end else begin
        if (start) m_ovr <= 1'b1;
        if (m_p < OFF) m_p <= m_p + 1;
        else if (res_ready) begin
          if (m_coef == COEFS - 1) begin m_active <= 1'b0; m_done <= 1'b1; end
          else begin m_coef <= m_coef + 1; m_p <= 0; end
        end
      end
    end
  end

  logic [12:0] obs, exp_v;
  assign obs = {busy, mac_clr, mac_ena, tap_idx, res_ld, res_valid, coef_idx, done, overrun};

  always_comb begin
    exp_v = {m_active,
             ena && m_active && (m_p == 0),
             ena && m_active && (m_p < TAPS),
             (m_active && m_p < TAPS) ? 3'(m_p) : 3'd0,
             ena && m_active && (m_p == LDP),
             m_active && (m_p == OFF),
             3'(m_coef), m_done, m_ovr};
  end

  task test_reset;
    #2 rst_n = 1'b0;
    #1 checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL reset_async obs=%h exp=0", obs); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; ena = 1'b1; res_ready = 1'b1;
    @(negedge clk); checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL reset_idle obs=%h exp=0", obs); end
  endtask

  task test_nominal;
    start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL nominal_model cyc=%0d obs=%h exp=%h", n, obs, exp_v); end
      checks++;
      if (mac_ena !== (n <= 96 && (n - 1) % 12 < 8) || mac_clr !== (n <= 96 && (n - 1) % 12 == 0)) begin
        errors++; $display("FAIL nominal_mac cyc=%0d ena=%b clr=%b", n, mac_ena, mac_clr);
      end
      checks++;
      if (res_ld !== (n <= 96 && n % 12 == 11)) begin errors++; $display("FAIL nominal_ld cyc=%0d got=%b", n, res_ld); end
      checks++;
      if (done !== (n == 97) || busy !== (n < 97)) begin
        errors++; $display("FAIL nominal_done cyc=%0d done=%b busy=%b", n, done, busy);
      end
      if (n <= 96) begin
        checks++;
        if (coef_idx !== 3'((n - 1) / 12)) begin errors++; $display("FAIL nominal_coef cyc=%0d got=%0d exp=%0d", n, coef_idx, (n - 1) / 12); end
      end
    end
  endtask

  task test_backpressure;
    start = 1'b1;
    for (int n = 1; n <= 104; n++) begin
      @(posedge clk); #1; start = 1'b0;
      res_ready = !(n >= 48 && n <= 52);
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bp_model cyc=%0d obs=%h exp=%h", n, obs, exp_v); end
      if (n >= 48 && n <= 53) begin
        checks++;
        if (res_valid !== 1'b1 || coef_idx !== 3'd3 || mac_ena !== 1'b0) begin
          errors++; $display("FAIL bp_stall cyc=%0d vld=%b coef=%0d mac=%b", n, res_valid, coef_idx, mac_ena);
        end
      end
      checks++;
      if (done !== (n == 102)) begin errors++; $display("FAIL bp_done cyc=%0d got=%b exp=%b", n, done, n == 102); end
    end
    res_ready = 1'b1;
  endtask

  task test_enable_stall;
    int exp_tap;
    exp_tap = 0;
    start = 1'b1;
    for (int n = 1; n <= 103; n++) begin
      @(posedge clk); #1; start = 1'b0;
      ena = !(n >= 5 && n <= 7);
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ena_model cyc=%0d obs=%h exp=%h", n, obs, exp_v); end
      if (n >= 5 && n <= 7) begin
        checks++;
        if (mac_ena !== 1'b0 || tap_idx !== 3'd4) begin errors++; $display("FAIL ena_hold cyc=%0d mac=%b tap=%0d", n, mac_ena, tap_idx); end
      end
      if (n <= 15 && mac_ena) begin
        checks++;
        if (tap_idx !== 3'(exp_tap)) begin errors++; $display("FAIL ena_tapseq cyc=%0d got=%0d exp=%0d", n, tap_idx, exp_tap); end
        exp_tap++;
      end
      checks++;
      if (done !== (n == 100)) begin errors++; $display("FAIL ena_done cyc=%0d got=%b exp=%b", n, done, n == 100); end
    end
    checks++;
    if (exp_tap != TAPS) begin errors++; $display("FAIL ena_tapcount got=%0d exp=%0d", exp_tap, TAPS); end
    ena = 1'b1;
  endtask

  task test_overrun;
    start = 1'b1;
    for (int n = 1; n <= 99; n++) begin
      @(posedge clk); #1;
      start = (n == 20);
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ovr_model cyc=%0d obs=%h exp=%h", n, obs, exp_v); end
      checks++;
      if (overrun !== (n >= 21) || done !== (n == 97)) begin
        errors++; $display("FAIL ovr_flag cyc=%0d ovr=%b done=%b", n, overrun, done);
      end
    end
    start = 1'b0;
  endtask

  task test_back_to_back;
    start = 1'b1;
    for (int n = 1; n <= 196; n++) begin
      @(posedge clk); #1;
      start = (n == 97);
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL b2b_model cyc=%0d obs=%h exp=%h", n, obs, exp_v); end
      checks++;
      if (done !== (n == 97 || n == 194) || mac_clr !== ((n <= 96 && (n - 1) % 12 == 0) || (n >= 98 && n <= 193 && (n - 98) % 12 == 0))) begin
        errors++; $display("FAIL b2b_seq cyc=%0d done=%b clr=%b", n, done, mac_clr);
      end
    end
    start = 1'b0;
  endtask

  task test_reset_mid_block;
    start = 1'b1;
    for (int n = 1; n <= 73; n++) begin
      @(posedge clk); #1; start = 1'b0;
      res_ready = (n < 72);
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_pre cyc=%0d obs=%h exp=%h", n, obs, exp_v); end
    end
    checks++;
    if (res_valid !== 1'b1 || coef_idx !== 3'd5) begin errors++; $display("FAIL rst_offer vld=%b coef=%0d", res_valid, coef_idx); end
    #2 rst_n = 1'b0;
    #1 checks++;
    if (obs !== 13'd0) begin errors++; $display("FAIL rst_mid obs=%h exp=0", obs); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b1; res_ready = 1'b1;
    for (int n = 1; n <= 98; n++) begin
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_post cyc=%0d obs=%h exp=%h", n, obs, exp_v); end
      checks++;
      if (res_valid !== (n <= 96 && n % 12 == 0) || done !== (n == 97)) begin
        errors++; $display("FAIL rst_clean cyc=%0d vld=%b done=%b", n, res_valid, done);
      end
      if (n <= 96) begin
        checks++;
        if (coef_idx !== 3'((n - 1) / 12)) begin errors++; $display("FAIL rst_coef cyc=%0d got=%0d", n, coef_idx); end
      end
    end
  endtask

  task test_random;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      ena       = ($urandom_range(0, 9) < 8);
      res_ready = $urandom_range(0, 1);
      start     = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", n, obs, exp_v); end
    end
    start = 1'b0; ena = 1'b1; res_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_enable_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid_block();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
